// File: rtl/sat_accumulator_if.sv
// ============================================================================
// Module      : sat_accumulator_if
// Description : Sample-in / frame-result-out valid/ready bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sat_accumulator_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_ovf_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_ovf_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_ovf_cnt
    );
endinterface

`default_nettype wire

// File: rtl/sat_accumulator.sv
// ============================================================================
// Module      : sat_accumulator
// Description : Frame-based signed accumulator with overflow saturate/wrap,
//               sticky overflow flag and overflow event count per frame.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_accumulator #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int SATURATE  = 1,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    sat_accumulator_if.slave     bus
);

    localparam int                  c_SCNT_W   = $clog2(FRAME_LEN + 1);
    localparam logic [0:0]          c_ST_ACCUM = 1'b0;
    localparam logic [0:0]          c_ST_HOLD  = 1'b1;
    localparam logic [WIDTH-1:0]    c_MAX      = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]    c_MIN      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [c_SCNT_W-1:0] c_LAST     = c_SCNT_W'(FRAME_LEN - 1);

    logic [0:0]          r_state;
    logic [WIDTH-1:0]    r_acc;
    logic [c_SCNT_W-1:0] r_scnt;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_ovf_cnt;
    logic [WIDTH-1:0]    r_out_sum;
    logic                r_out_ovf;
    logic [CNT_W-1:0]    r_out_ovf_cnt;

    logic [WIDTH-1:0]    w_sum;
    logic                w_ovf;
    logic [WIDTH-1:0]    w_acc_nxt;
    logic                w_flag_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    always_comb begin
        w_sum      = r_acc + bus.in_data;
        w_ovf      = (r_acc[WIDTH-1] == bus.in_data[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
        w_acc_nxt  = w_sum;
        if (w_ovf && (SATURATE != 0)) begin
            w_acc_nxt = r_acc[WIDTH-1] ? c_MIN : c_MAX;
        end
        w_flag_nxt = r_ovf | w_ovf;
        // Event counter sticks at all-ones instead of wrapping
        w_cnt_nxt  = r_ovf_cnt;
        if (w_ovf && (r_ovf_cnt != {CNT_W{1'b1}})) begin
            w_cnt_nxt = r_ovf_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_ACCUM;
            r_acc         <= '0;
            r_scnt        <= '0;
            r_ovf         <= 1'b0;
            r_ovf_cnt     <= '0;
            r_out_sum     <= '0;
            r_out_ovf     <= 1'b0;
            r_out_ovf_cnt <= '0;
        end else if (clear) begin
            r_state   <= c_ST_ACCUM;
            r_acc     <= '0;
            r_scnt    <= '0;
            r_ovf     <= 1'b0;
            r_ovf_cnt <= '0;
        end else if (r_state == c_ST_HOLD) begin
            if (bus.out_ready) begin
                r_state   <= c_ST_ACCUM;
                r_acc     <= '0;
                r_scnt    <= '0;
                r_ovf     <= 1'b0;
                r_ovf_cnt <= '0;
            end
        end else if (bus.in_valid) begin
            r_acc     <= w_acc_nxt;
            r_ovf     <= w_flag_nxt;
            r_ovf_cnt <= w_cnt_nxt;
            if (r_scnt == c_LAST) begin
                r_scnt        <= '0;
                r_state       <= c_ST_HOLD;
                r_out_sum     <= w_acc_nxt;
                r_out_ovf     <= w_flag_nxt;
                r_out_ovf_cnt <= w_cnt_nxt;
            end else begin
                r_scnt <= r_scnt + 1'b1;
            end
        end
    end

    assign bus.in_ready    = (r_state == c_ST_ACCUM);
    assign bus.out_valid   = (r_state == c_ST_HOLD);
    assign bus.out_sum     = r_out_sum;
    assign bus.out_ovf     = r_out_ovf;
    assign bus.out_ovf_cnt = r_out_ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sat_accumulator.sv
// ============================================================================
// Module      : tb_sat_accumulator
// Description : Scoreboard bench driving a wrapping and a saturating instance
//               with identical stimulus against a frame-level reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sat_accumulator;

    typedef struct {
        logic [7:0] sum;
        logic       ovf;
        logic [7:0] cnt;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sat_accumulator_if #(.WIDTH(8), .CNT_W(8)) bus0 ();
    sat_accumulator_if #(.WIDTH(8), .CNT_W(8)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.out_ready = out_ready;

    // index 0 wraps, index 1 saturates
    sat_accumulator #(.WIDTH(8), .FRAME_LEN(4), .SATURATE(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus0));
    sat_accumulator #(.WIDTH(8), .FRAME_LEN(4), .SATURATE(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus1));

    logic       o_valid [2];
    logic       o_ready [2];
    logic [7:0] o_sum   [2];
    logic       o_ovf   [2];
    logic [7:0] o_cnt   [2];

    assign o_valid[0] = bus0.out_valid;   assign o_valid[1] = bus1.out_valid;
    assign o_ready[0] = bus0.in_ready;    assign o_ready[1] = bus1.in_ready;
    assign o_sum[0]   = bus0.out_sum;     assign o_sum[1]   = bus1.out_sum;
    assign o_ovf[0]   = bus0.out_ovf;     assign o_ovf[1]   = bus1.out_ovf;
    assign o_cnt[0]   = bus0.out_ovf_cnt; assign o_cnt[1]   = bus1.out_ovf_cnt;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Frame result from plain integer arithmetic over the accepted samples
    function automatic res_t ref_frame(input logic [7:0] smp[$], input bit sat);
        res_t r;
        int   acc = 0;
        int   cnt = 0;
        bit   f   = 1'b0;
        foreach (smp[i]) begin
            int t = acc + int'($signed(smp[i]));
            if (t > 127 || t < -128) begin
                f = 1'b1;
                if (cnt < 255) cnt++;
                if (sat) acc = (t > 127) ? 127 : -128;
                else     acc = (t > 127) ? t - 256 : t + 256;
            end else begin
                acc = t;
            end
        end
        r.sum = acc[7:0];
        r.ovf = f;
        r.cnt = cnt[7:0];
        return r;
    endfunction

    // Reference model state
    bit         checking = 1'b0;
    bit         m_hold   = 1'b0;
    logic [7:0] m_frame[$];
    res_t       m_out[2];
    res_t       exp_q0[$];
    res_t       exp_q1[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hold = 1'b0;
            m_frame.delete();
            for (int k = 0; k < 2; k++) begin
                m_out[k].sum = 8'h00;
                m_out[k].ovf = 1'b0;
                m_out[k].cnt = 8'h00;
            end
            checking = 1'b1;
        end else if (clear) begin
            m_hold = 1'b0;
            m_frame.delete();
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            m_frame.push_back(in_data);
            if (m_frame.size() == 4) begin
                m_out[0] = ref_frame(m_frame, 1'b0);
                m_out[1] = ref_frame(m_frame, 1'b1);
                exp_q0.push_back(m_out[0]);
                exp_q1.push_back(m_out[1]);
                m_frame.delete();
                m_hold = 1'b1;
            end
        end
    end

    // Monitor: pops one expected result each time a DUT raises out_valid
    bit prev_v[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                res_t e;
                check("in_ready", k, 32'(o_ready[k]), 32'(!m_hold));
                check("out_valid", k, 32'(o_valid[k]), 32'(m_hold));
                if (o_valid[k] && !prev_v[k]) begin
                    if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        check("sb_unexpected_result", k, 32'd1, 32'd0);
                    end else begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check("sb_sum", k, 32'(o_sum[k]), 32'(e.sum));
                        check("sb_ovf", k, 32'(o_ovf[k]), 32'(e.ovf));
                        check("sb_cnt", k, 32'(o_cnt[k]), 32'(e.cnt));
                    end
                end
                check("hold_sum", k, 32'(o_sum[k]), 32'(m_out[k].sum));
                check("hold_ovf", k, 32'(o_ovf[k]), 32'(m_out[k].ovf));
                check("hold_cnt", k, 32'(o_cnt[k]), 32'(m_out[k].cnt));
                prev_v[k] = o_valid[k];
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] d, input bit ordy,
                         input bit clr, input bit rn);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        rst_n     = rn;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        drive(1'b1, a, 1'b1, 1'b0, 1'b1);
        drive(1'b1, b, 1'b1, 1'b0, 1'b1);
        drive(1'b1, c, 1'b1, 1'b0, 1'b1);
        drive(1'b1, d, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic plan(input string name, input int k, input logic [7:0] s,
                        input logic o, input logic [7:0] c);
        check({name, "_sum"}, k, 32'(o_sum[k]), 32'(s));
        check({name, "_ovf"}, k, 32'(o_ovf[k]), 32'(o));
        check({name, "_cnt"}, k, 32'(o_cnt[k]), 32'(c));
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        frame(8'h12, 8'h56, 8'h01, 8'h02);
        plan("no_ovf", 1, 8'h6B, 1'b0, 8'd0);
        frame(8'h70, 8'h75, 8'h01, 8'h00);
        plan("pos_sat", 1, 8'h7F, 1'b1, 8'd2);
        frame(8'h90, 8'h90, 8'h98, 8'h12);
        plan("neg_sat", 1, 8'h92, 1'b1, 8'd2);
        plan("neg_wrap", 0, 8'hCA, 1'b1, 8'd1);

        // Backpressure with offered-but-ignored samples
        drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h06, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        plan("bp_hold", 1, 8'h1A, 1'b0, 8'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Clear mid-frame, with a dropped sample on the clear cycle
        drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h30, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h7F, 1'b0, 1'b1, 1'b1);
        frame(8'h01, 8'h02, 8'h03, 8'h04);
        plan("clear_frame", 1, 8'h0A, 1'b0, 8'd0);
        plan("clear_frame", 0, 8'h0A, 1'b0, 8'd0);

        // Reset while a result is pending
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h7F, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        plan("after_rst", 1, 8'h00, 1'b0, 8'd0);
        check("after_rst_valid", 1, 32'(o_valid[1]), 32'd0);
        frame(8'h01, 8'h01, 8'h01, 8'h01);
        plan("post_rst_frame", 1, 8'h04, 1'b0, 8'd0);

        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 149) != 0);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("queue_drained", 0, 32'(exp_q0.size()), 32'd0);
        check("queue_drained", 1, 32'(exp_q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sat_accumulator.md
Name: sat_accumulator

Overview:
- Downstream consumer of the 8-bit signed add/overflow stage.
- Accumulates a stream of two's-complement operands into a running sum over fixed-length frames.
- Detects signed overflow on every add, and either saturates or wraps.
- At the end of each frame it presents the sum, a sticky overflow flag and an overflow count on a valid/ready output port.

Parameters:
- WIDTH, 8, operand and accumulator width (two's complement).
- FRAME_LEN, 4, number of accepted samples per frame (≥2).
- SATURATE, 1, 1 = clamp to max/min on overflow; 0 = wrap (keep truncated sum).
- CNT_W, 8, width of overflow event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- clear  input  1  synchronous frame abort, active-high.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  WIDTH  signed operand.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  final accumulated sum of frame.
- out_ovf  output  1  sticky: at least one overflow occurred in frame.
- out_ovf_cnt  output  CNT_W  number of overflowing adds in frame.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (rst_n sampled on clk rising edge).
- Reset: state=ACCUM; acc, sample count, ovf flag, ovf count = 0; out_valid=0; out_sum=0; out_ovf=0; out_ovf_cnt=0.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1, outputs stable.
- Accept: in_valid && in_ready at a rising edge.
- Per accepted sample:
  - s = acc + in_data, truncated to WIDTH.
  - ovf = (acc[MSB]==in_data[MSB]) && (s[MSB]!=acc[MSB]).
  - Next acc: if ovf && SATURATE, 0x7F..F when acc[MSB]=0, else 0x80..0. Otherwise next acc = s.
  - ovf flag |= ovf.
  - ovf count += ovf, saturating at 2^CNT_W-1 (no wrap).
  - Sample count += 1.
- Frame end: the accept that makes sample count == FRAME_LEN latches the next acc, flag and count into out_sum, out_ovf and out_ovf_cnt. State goes to HOLD on the same edge.
  - out_valid rises the cycle after the last accept (latency 1).
- HOLD exit: on out_valid && out_ready, go to ACCUM with acc, sample count, flag and ovf count = 0. out_valid drops on the next cycle.
  - out_sum, out_ovf and out_ovf_cnt keep their last values until the next frame end.
  - The first new sample can be accepted the cycle after the handshake; no same-cycle pass-through.
- Backpressure: in HOLD, in_valid is ignored and nothing is consumed. Outputs must not change while out_valid && !out_ready.
- clear (rst_n=1): go to ACCUM and zero acc, sample count, flag and ovf count. out_valid goes to 0, even from HOLD; the pending result is discarded.
  - A sample offered in the same cycle as clear is dropped and not counted.
  - out_sum, out_ovf and out_ovf_cnt are not cleared by clear.
- Priority: rst_n low > clear > out handshake > input accept.
- Reset or clear mid-frame fully discards the partial frame. There is no partial-result output.
- in_data is interpreted signed only; no sign extension beyond WIDTH.

Test Plan (WIDTH=8, FRAME_LEN=4, CNT_W=8):
- No overflow, SATURATE=1: samples 0x12, 0x56, 0x01, 0x02 with out_ready=1 -> out_valid one cycle after 4th accept; out_sum=0x6B, out_ovf=0, out_ovf_cnt=0.
- Positive saturation, SATURATE=1: 0x70, 0x75, 0x01, 0x00 -> acc 0x70 -> 0x7F (ovf) -> 0x7F (ovf) -> 0x7F; out_sum=0x7F, out_ovf=1, out_ovf_cnt=2.
- Negative saturation vs wrap: 0x90, 0x90, 0x98, 0x12.
  - SATURATE=1: out_sum=0x92, out_ovf=1, out_ovf_cnt=2.
  - SATURATE=0: acc 0x90 -> 0x20 (ovf) -> 0xB8 -> 0xCA; out_sum=0xCA, out_ovf=1, out_ovf_cnt=1.
- Backpressure: complete a frame, hold out_ready=0 for 5 cycles while driving in_valid=1 with 0x11.
  - Required: out_valid stays 1, in_ready stays 0, outputs stable, 0x11 not consumed.
  - On out_ready=1: handshake, then in_ready=1 the next cycle.
- Clear mid-frame: accept 0x40, 0x30, then assert clear with in_valid=1 and in_data=0x7F (dropped). Then feed 0x01, 0x02, 0x03, 0x04 -> out_sum=0x0A, out_ovf=0, out_ovf_cnt=0.
- Reset in HOLD: drive rst_n=0 for one edge while out_valid=1 -> out_valid=0, out_sum=0, out_ovf=0, out_ovf_cnt=0, in_ready=1 after release. The next frame 0x01×4 gives out_sum=0x04.
